data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in internal storage (power of two).
REQ-002 SHALL have parameter AW, default 10, meaning the word-index width (log2 DEPTH).
REQ-003 SHALL have port Clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Address  input  32  byte address from EX/MEM.
REQ-006 SHALL have port WriteData  input  32  store data; sb uses [7:0], sh uses [15:0].
REQ-007 SHALL have port MemRead  input  2  load request: 0 none, 1 lw, 2 lb, 3 lh.
REQ-008 SHALL have port MemWrite  input  2  store request: 0 none, 1 sw, 2 sb, 3 sh.
REQ-009 SHALL have port Stall  output  1  pipeline hold request; upstream freezes while it is 1.
REQ-010 SHALL have port MemWord  output  32  raw addressed word, for the downstream load-extract stage.
REQ-011 SHALL have port ByteOffset  output  2  Address[1:0] of the load that produced MemWord.
REQ-012 SHALL have port LoadType  output  2  MemRead code of the load that produced MemWord.
REQ-013 SHALL have port DataValid  output  1  one-cycle pulse when MemWord, ByteOffset and LoadType are new.
REQ-014 SHALL have port AlignErr  output  1  one-cycle pulse on a misaligned request.

Function
REQ-015 Word index SHALL be Address[AW+1:2]; higher address bits SHALL be ignored.
REQ-016 Byte lanes SHALL be big-endian: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
REQ-017 The FSM SHALL have states IDLE, LOAD, RMW_RD and RMW_WR; new requests SHALL be accepted only in IDLE.
REQ-018 In IDLE, the address, data, offset and request codes SHALL be captured into internal registers; inputs need not be held stable after the capture edge.
REQ-019 A store SHALL take priority over a load when both are nonzero; the load SHALL be dropped.
REQ-020 sw: the word SHALL be written on the capture edge; Stall SHALL remain 0; the FSM SHALL stay in IDLE.
REQ-021 lw/lb/lh: Stall SHALL be 1 in the capture cycle, and the FSM SHALL go to LOAD.
REQ-022 In LOAD, the registered read SHALL drive MemWord; DataValid SHALL be 1 and Stall SHALL be 0; the FSM SHALL return to IDLE.
REQ-023 Load latency SHALL be exactly one stall cycle.
REQ-024 sb/sh: Stall SHALL be 1 in the capture cycle and in RMW_RD, where the old word is registered.
REQ-025 In RMW_WR, the merged word SHALL be written, with only the addressed lane(s) replaced; Stall SHALL be 0; the FSM SHALL return to IDLE.
REQ-026 A store SHALL therefore impose two stall cycles.
REQ-027 Misalignment SHALL be Address[1:0] != 0 for lw/sw, and Address[0] = 1 for lh/sh.
REQ-028 On misalignment: AlignErr SHALL pulse one cycle; there SHALL be no memory access and no stall; MemWord SHALL be unchanged.
REQ-029 MemWord, ByteOffset and LoadType SHALL hold their values until the next DataValid.
REQ-030 MemRead = 0 and MemWrite = 0 in IDLE SHALL be a no-op.
REQ-031 A store followed immediately by a load to the same word SHALL return the post-store value.

Reset
REQ-032 Asserting Rst SHALL immediately force the FSM to IDLE and clear Stall, DataValid and AlignErr.
REQ-033 Asserting Rst SHALL immediately clear MemWord to 0x00000000, and ByteOffset and LoadType to 0.
REQ-034 Reset during RMW_RD or RMW_WR SHALL abort the store with no write.
REQ-035 The storage array SHALL NOT be reset; it SHALL be zero at simulation start.

Structure
REQ-036 Package mem_pkg SHALL hold the MemRead/MemWrite encodings, the FSM state type and the DEPTH/AW defaults.
REQ-037 Lane merging SHALL be a combinational sub-module store_merge (inputs: old word, WriteData, offset, MemWrite code; output: merged word).

Verification
REQ-038 sw 0xDEADBEEF @0x10, then lw @0x10 -> Stall 1 for one cycle; DataValid with MemWord 0xDEADBEEF, ByteOffset 0, LoadType 1.
REQ-039 After REQ-038, sb 0x55 @0x12, then lw @0x10 -> Stall 1 for two cycles on the sb; MemWord 0xDEAD55EF.
REQ-040 After REQ-039, sh 0x1234 @0x10, then lb @0x11 -> MemWord 0x123455EF, ByteOffset 1, LoadType 2.
REQ-041 lh @0x13 and sw @0x06 -> AlignErr pulses each time, Stall stays 0, memory and MemWord unchanged.
REQ-042 sb @0x20 with Rst asserted in RMW_RD -> Stall 0 and IDLE immediately; later lw @0x20 returns the pre-store word.
REQ-043 MemRead 1 and MemWrite 1 together @0x30 -> word written, DataValid never pulses.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and defaults for the data-memory controller.
// Request codes mirror the EX/MEM MemRead/MemWrite fields.
package mem_pkg;

    localparam int DEFAULT_DEPTH = 1024;
    localparam int DEFAULT_AW    = 10;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_LW   = 2'd1,
        RD_LB   = 2'd2,
        RD_LH   = 2'd3
    } mem_rd_e;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_SW   = 2'd1,
        WR_SB   = 2'd2,
        WR_SH   = 2'd3
    } mem_wr_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_RMW_RD = 2'd2,
        ST_RMW_WR = 2'd3
    } mem_state_e;

    // Word accesses need a 4-byte boundary, halfword accesses a 2-byte one.
    function automatic logic is_misaligned(input logic word_acc, input logic half_acc,
                                           input logic [1:0] off);
        return (word_acc && (off != 2'b00)) || (half_acc && off[0]);
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// EX/MEM-side request bus and MEM-side response signals of the controller.
// Handshake: a request is taken in the cycle it is presented while Stall is 0 after it;
// while Stall is 1 the pipeline holds the request unchanged and the controller ignores it.
interface data_mem_ctrl_if;

    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [1:0]  MemRead;
    logic [1:0]  MemWrite;
    logic        Stall;
    logic [31:0] MemWord;
    logic [1:0]  ByteOffset;
    logic [1:0]  LoadType;
    logic        DataValid;
    logic        AlignErr;

    modport master (
        output Address, WriteData, MemRead, MemWrite,
        input  Stall, MemWord, ByteOffset, LoadType, DataValid, AlignErr
    );

    modport slave (
        input  Address, WriteData, MemRead, MemWrite,
        output Stall, MemWord, ByteOffset, LoadType, DataValid, AlignErr
    );

endinterface

// File: rtl/store_merge.sv
// Replaces the addressed big-endian byte/halfword lane(s) of an old word with store data.
module store_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  mem_wr_e     wr_code,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (wr_code)
            WR_SW: merged = wdata;
            WR_SB: begin
                case (offset)
                    2'd0:    merged[31:24] = wdata[7:0];
                    2'd1:    merged[23:16] = wdata[7:0];
                    2'd2:    merged[15:8]  = wdata[7:0];
                    default: merged[7:0]   = wdata[7:0];
                endcase
            end
            WR_SH: begin
                if (offset[1]) merged[15:0]  = wdata[15:0];
                else           merged[31:16] = wdata[15:0];
            end
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word storage with a one-stall registered load and
// a two-stall read-modify-write path for byte/halfword stores.
module data_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = DEFAULT_AW
) (
    input  logic           Clk,
    input  logic           Rst,
    data_mem_ctrl_if.slave bus,
    output mem_state_e     dbg_state
);

    logic [31:0] mem [DEPTH];

    mem_state_e    state;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [31:0]   old_q;
    logic [1:0]    off_q;
    mem_wr_e       wcode_q;
    logic [31:0]   merged;

    logic [31:0]   mem_word_q;
    logic [1:0]    byte_off_q;
    mem_rd_e       load_type_q;
    logic          data_valid_q;
    logic          align_err_q;

    mem_rd_e       rd_code;
    mem_wr_e       wr_code;
    logic [AW-1:0] req_idx;
    logic [1:0]    req_off;
    logic          is_store;
    logic          is_load;
    logic          misaligned;
    logic          accept;
    logic          accept_sw;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          unused_addr_bits;

    assign rd_code  = mem_rd_e'(bus.MemRead);
    assign wr_code  = mem_wr_e'(bus.MemWrite);
    assign req_idx  = bus.Address[AW+1:2];
    assign req_off  = bus.Address[1:0];
    assign unused_addr_bits = ^bus.Address[31:AW+2];

    // A store wins over a simultaneous load; the load is simply dropped.
    assign is_store   = (wr_code != WR_NONE);
    assign is_load    = !is_store && (rd_code != RD_NONE);
    assign misaligned = is_store ? is_misaligned(wr_code == WR_SW, wr_code == WR_SH, req_off)
                                 : is_misaligned(rd_code == RD_LW, rd_code == RD_LH, req_off);
    assign accept     = Rst && (state == ST_IDLE) && (is_store || is_load) && !misaligned;
    assign accept_sw  = accept && is_store && (wr_code == WR_SW);

    store_merge u_merge (
        .old_word (old_q),
        .wdata    (wdata_q),
        .offset   (off_q),
        .wr_code  (wcode_q),
        .merged   (merged)
    );

    // Full-word stores go straight in; sub-word stores land at the end of RMW_WR.
    assign mem_we    = accept_sw || (Rst && (state == ST_RMW_WR));
    assign mem_waddr = accept_sw ? req_idx : idx_q;
    assign mem_wdata = accept_sw ? bus.WriteData : merged;

    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state        <= ST_IDLE;
            idx_q        <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            off_q        <= '0;
            wcode_q      <= WR_NONE;
            mem_word_q   <= '0;
            byte_off_q   <= '0;
            load_type_q  <= RD_NONE;
            data_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((is_store || is_load) && misaligned) begin
                        align_err_q <= 1'b1;
                    end else if (is_store) begin
                        idx_q   <= req_idx;
                        wdata_q <= bus.WriteData;
                        off_q   <= req_off;
                        wcode_q <= wr_code;
                        if (wr_code != WR_SW) state <= ST_RMW_RD;
                    end else if (is_load) begin
                        mem_word_q   <= mem[req_idx];
                        byte_off_q   <= req_off;
                        load_type_q  <= rd_code;
                        data_valid_q <= 1'b1;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD:   state <= ST_IDLE;
                ST_RMW_RD: begin
                    old_q <= mem[idx_q];
                    state <= ST_RMW_WR;
                end
                ST_RMW_WR: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign bus.Stall      = Rst && ((accept && !accept_sw) || (state == ST_RMW_RD));
    assign bus.MemWord    = mem_word_q;
    assign bus.ByteOffset = byte_off_q;
    assign bus.LoadType   = load_type_q;
    assign bus.DataValid  = data_valid_q;
    assign bus.AlignErr   = align_err_q;
    assign dbg_state      = state;

endmodule
